riscv_wb_arbiter: RTL
=====================

// Module: riscv_wb_arbiter
// PURPOSE
//  Write-back arbiter that drives the register-file write port (we/waddr/wdata).
//  Merges results from the single-cycle ALU path and the load path onto one port:
//  - ALU results have priority and are never stalled.
//  - Loads are byte/half extended, then buffered in a small FIFO when the port is busy.
//  Preserves WAW order and never writes x0.
// PARAMETERS
//  DEPTH  4  load-result FIFO entries; power of 2, >=2
// PORTS
//  clk            in   1   clock; single clock domain
//  rst_n          in   1   synchronous active-low reset, sampled on posedge clk
//  i_alu_valid    in   1   ALU result valid this cycle; no backpressure
//  i_alu_rd       in   5   ALU destination register
//  i_alu_data     in   32  ALU result
//  i_mem_valid    in   1   load result valid
//  o_mem_ready    out  1   load result accepted when valid&ready
//  i_mem_rd       in   5   load destination register
//  i_mem_funct3   in   3   load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
//  i_mem_addr_lo  in   2   byte address bits [1:0] of the load
//  i_mem_data     in   32  raw aligned memory word
//  o_we           out  1   register-file write enable
//  o_waddr        out  5   register-file write address
//  o_wdata        out  32  register-file write data
//  o_busy_mask    out  32  bit r set = a queued, not-yet-written load targets r
// BEHAVIOUR
//  Reset: o_we=0, o_waddr=0, o_wdata=0, o_busy_mask=0, FIFO emptied; o_mem_ready=1 after reset.
//  o_mem_ready = !fifo_full. This is combinational from FIFO state only, never from i_mem_valid.
//  Load extension (in the accept cycle):
//  - LB/LBU: byte[addr_lo]; LB sign-extends, LBU zero-extends.
//  - LH/LHU: half[addr_lo[1]]; addr_lo[0] ignored. LH sign-extends, LHU zero-extends.
//  - LW and all other funct3 values: the full word.
//  Port selection each cycle, evaluated in order:
//  - ALU valid and rd!=0: registered write of the ALU result.
//  - Else, FIFO head valid: registered write of the head entry, and the head is popped.
//  - Else, load accepted and FIFO empty: direct registered write of the load result (bypasses the FIFO).
//  - Otherwise: o_we=0.
//  Latency: one cycle from input to o_we/o_waddr/o_wdata (outputs are registers).
//  Enqueue: an accepted load with rd!=0 is pushed when the port is taken by the ALU
//   or the FIFO holds an earlier entry. A push and a pop in the same cycle are legal.
//  Ordering: loads are written in acceptance order (FIFO).
//  x0: rd=0 results from either port are dropped (load still handshakes); o_we never 1 with waddr 0.
//  WAW kill: an ALU write to rd clears the valid bit of every queued entry with the same rd.
//  Same-cycle conflict: an accepted load with the same rd as the ALU write is discarded, not enqueued.
//  Killed head entries pop in the cycle they reach the head, without asserting o_we.
//  o_busy_mask: OR of one-hot(rd) over valid FIFO entries. Registered; updates the cycle after a push/pop/kill.
//  Full FIFO with i_mem_valid: no accept; data must be held by the source (standard valid/ready).
//  Reset mid-drain: all queued entries are lost; o_we=0 the cycle after reset is sampled.
//  Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and LSBs are equal.
// TESTING
//  1. Hold rst_n=0 for 2 cycles -> o_we=0, o_busy_mask=0, o_mem_ready=1.
//  2. ALU rd=5, data=0x1234 for 1 cycle -> next cycle o_we=1, waddr=5, wdata=0x00001234.
//  3. Load LB, addr_lo=3, data=0x80000000, rd=2 -> wdata=0xFFFFFF80.
//     Load LHU, addr_lo=2, data=0xBEEF0000 -> wdata=0x0000BEEF.
//  4. ALU valid 6 cycles (rd 1..6) with 5 back-to-back loads (rd 10..14):
//     4 loads queued, o_mem_ready=0 on the 5th, 5th stalls until a pop.
//     After the ALU stops, writes go rd 10,11,12,13,14 in order.
//  5. Queue load rd=7; next cycle ALU rd=7, data=0xA, with the port held by the ALU ->
//     only 0xA is written to x7, o_busy_mask[7] clears, no later write to 7.
//  6. ALU rd=0 and load rd=0 together -> o_we stays 0, load handshake completes.
//  7. Reset asserted with 3 queued entries -> FIFO empty, o_busy_mask=0, no further o_we.

Source files
------------

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter
//   Write-back arbiter for the register-file write port. ALU results take the
//   port unconditionally; load results are byte/half extended on acceptance and
//   either written directly or queued in a small in-order FIFO. A queued load
//   whose destination is overwritten by a later ALU write is killed, so
//   write-after-write order is preserved. Writes to x0 are never issued.
//
//   Ports
//     clk, rst_n                    clock, synchronous active-low reset
//     i_alu_valid/rd/data           ALU result (no backpressure)
//     i_mem_valid, o_mem_ready      load-result handshake
//     i_mem_rd/funct3/addr_lo/data  load destination, type, byte offset, raw word
//     o_we/o_waddr/o_wdata          registered register-file write port
//     o_busy_mask                   one bit per register with a live queued load
module riscv_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_mem_valid,
  output logic        o_mem_ready,
  input  logic [4:0]  i_mem_rd,
  input  logic [2:0]  i_mem_funct3,
  input  logic [1:0]  i_mem_addr_lo,
  input  logic [31:0] i_mem_data,
  output logic        o_we,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata,
  output logic [31:0] o_busy_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // FIFO storage; ent_vld marks occupied slots that have not been killed
  logic [4:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    wr_ptr, rd_ptr;

  logic             we_p1;
  logic [4:0]       waddr_p1;
  logic [31:0]      wdata_p1;
  logic [31:0]      busy_p1;

  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  logic             fifo_full, fifo_empty;
  logic [AW-1:0]    head_idx, tail_idx;
  logic             alu_take, accept, keep_load, bypass, push, pop;
  logic             head_live, head_dead;
  logic [31:0]      load_data;
  logic             we_p0;
  logic [4:0]       waddr_p0;
  logic [31:0]      wdata_p0;
  logic [DEPTH-1:0] vld_nxt;
  logic [31:0]      busy_p0;
  logic [4:0]       rd_nxt;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_idx    = rd_ptr[AW-1:0];
  assign tail_idx    = wr_ptr[AW-1:0];
  assign o_mem_ready = !fifo_full;

  // Stage p0: port selection, FIFO push/pop/kill decisions
  always_comb begin
    alu_take  = i_alu_valid && (i_alu_rd != 5'd0);
    accept    = i_mem_valid && !fifo_full;
    load_data = load_extend(i_mem_funct3, i_mem_addr_lo, i_mem_data);
    head_live = !fifo_empty && ent_vld[head_idx];
    head_dead = !fifo_empty && !ent_vld[head_idx];
    // A load racing an ALU write to the same rd is already stale
    keep_load = accept && (i_mem_rd != 5'd0) &&
                !(alu_take && (i_mem_rd == i_alu_rd));
    bypass    = keep_load && !alu_take && fifo_empty;
    push      = keep_load && !bypass;
    // Killed heads are discarded even while the ALU holds the port
    pop       = head_dead || (head_live && !alu_take);

    we_p0    = 1'b0;
    waddr_p0 = 5'd0;
    wdata_p0 = 32'd0;
    if (alu_take) begin
      we_p0    = 1'b1;
      waddr_p0 = i_alu_rd;
      wdata_p0 = i_alu_data;
    end else if (head_live) begin
      we_p0    = 1'b1;
      waddr_p0 = ent_rd[head_idx];
      wdata_p0 = ent_data[head_idx];
    end else if (bypass) begin
      we_p0    = 1'b1;
      waddr_p0 = i_mem_rd;
      wdata_p0 = load_data;
    end

    vld_nxt = ent_vld;
    busy_p0 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_take && (ent_rd[i] == i_alu_rd)) vld_nxt[i] = 1'b0;
      if (pop && (head_idx == AW'(i)))         vld_nxt[i] = 1'b0;
      if (push && (tail_idx == AW'(i)))        vld_nxt[i] = 1'b1;
      rd_nxt = (push && (tail_idx == AW'(i))) ? i_mem_rd : ent_rd[i];
      if (vld_nxt[i]) busy_p0[rd_nxt] = 1'b1;
    end
  end

  // Stage p1: registered write port, FIFO control state and busy mask
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_p1    <= 1'b0;
      waddr_p1 <= 5'd0;
      wdata_p1 <= 32'd0;
      busy_p1  <= 32'd0;
      ent_vld  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      we_p1    <= we_p0;
      waddr_p1 <= waddr_p0;
      wdata_p1 <= wdata_p0;
      busy_p1  <= busy_p0;
      ent_vld  <= vld_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[tail_idx]   <= i_mem_rd;
      ent_data[tail_idx] <= load_data;
    end
  end

  assign o_we        = we_p1;
  assign o_waddr     = waddr_p1;
  assign o_wdata     = wdata_p1;
  assign o_busy_mask = busy_p1;

endmodule
